neighbour_counter: RTL and testbench
====================================

NEIGHBOUR_COUNTER -- requirements
Module: neighbour_counter

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle request to scan the mine board.
REQ-004 dimension_size  input  5  board edge length; legal values 8, 10, 16.
REQ-005 mine_rd_en  output  1  read strobe to the mine board.
REQ-006 mine_rd_x, mine_rd_y  output  5 each  read address (column, row).
REQ-007 mine_rd_data  input  1  mine bit for the address of the previous mine_rd_en cycle (1 cycle latency).
REQ-008 cnt_wr_en  output  1  write strobe to the number board.
REQ-009 cnt_wr_x, cnt_wr_y  output  5 each  write address.
REQ-010 cnt_wr_data  output  4  neighbour count 0..8, or 4'hF for a mine cell.
REQ-011 busy  output  1  high from accepted start until done.
REQ-012 done  output  1  one-cycle pulse when the scan is complete.

Function
REQ-013 FSM states: IDLE, ISSUE, DRAIN, WRITE, NEXT, DONE.
REQ-014 In IDLE, start with dimension_size in {8,10,16} is accepted; dimension_size is latched; cell pointer set to (0,0); next state ISSUE.
REQ-015 In IDLE, start with an illegal dimension_size is ignored; busy and done stay low.
REQ-016 start while busy is ignored.
REQ-017 Cells visited row-major: x increments 0..N-1 inside y 0..N-1.
REQ-018 ISSUE lasts exactly 9 cycles, slot k=0..8, offsets in order (-1,-1),(0,-1),(+1,-1),(-1,0),(0,0),(+1,0),(-1,+1),(0,+1),(+1,+1).
REQ-019 Slot in bounds (0 <= coord < N): mine_rd_en=1, address = cell+offset.
REQ-020 Slot out of bounds: mine_rd_en=0, mine_rd_x/y=0, slot contributes 0; cycle still consumed.
REQ-021 mine_rd_data is accumulated in the cycle after its valid read; slot 4 (centre) sets a centre_mine flag instead of adding to the count.
REQ-022 DRAIN (1 cycle) accumulates slot 8 data; no read issued.
REQ-023 WRITE (1 cycle): cnt_wr_en=1, address = cell, data = 4'hF if centre_mine else count (4-bit, max 8, no overflow).
REQ-024 NEXT (1 cycle): clears count and centre_mine, advances pointer; wraps x to 0 and increments y at x=N-1; after cell (N-1,N-1) goes to DONE, else ISSUE.
REQ-025 Cell period is 12 cycles; full scan ends N*N*12 cycles after start acceptance (768/1200/3072 for N=8/10/16).
REQ-026 DONE: done=1 for one cycle, busy=0 in that cycle, return to IDLE.
REQ-027 mine_rd_en and cnt_wr_en never assert in the same cycle.

Reset
REQ-028 rst low forces IDLE asynchronously, even mid-scan; no partial write is completed.
REQ-029 Reset values: all outputs 0; count, centre_mine, pointer, latched size 0.
REQ-030 After rst release, the block waits for a new start; there is no automatic resume.

Structure
REQ-031 Shared package saper_pkg holds the FSM state enum, CELL_MINE=4'hF, legal sizes 8/10/16, and the 9-entry offset table.
REQ-032 One combinational sub-module, neighbour_addr_gen, maps (cell x/y, slot, N) to (in_bounds, rd_x, rd_y).
REQ-033 All other logic lives in neighbour_counter; outputs are registered.

Verification
REQ-034 N=8, no mines, start -> 64 writes all 0, row-major, done at cycle 768, busy low after.
REQ-035 N=8, single mine at (3,3) -> (3,3)=F; its 8 neighbours=1; all other cells=0.
REQ-036 N=10, mines at (0,0),(1,0),(0,1) -> (1,1)=3, (0,0)=F; corner reads with mine_rd_en=0 for the 5 out-of-bounds slots.
REQ-037 N=16, all cells mines -> 256 writes of F; done at cycle 3072.
REQ-038 dimension_size=9 with start -> no reads, busy stays 0; second start mid-scan ignored; rst low mid-scan -> all outputs 0 immediately, no done.

Source files
------------

// File: rtl/saper_pkg.sv
// Shared definitions for the mine-board neighbour counter: FSM states,
// the mine marker value, legal board sizes and the 3x3 neighbourhood offsets.
package saper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Value written for a cell that itself holds a mine.
  localparam logic [3:0] CELL_MINE = 4'hF;

  // Legal board edge lengths.
  localparam logic [4:0] SIZE_S = 5'd8;
  localparam logic [4:0] SIZE_M = 5'd10;
  localparam logic [4:0] SIZE_L = 5'd16;

  // Neighbourhood slots: 0..8, slot 4 is the cell itself.
  localparam logic [3:0] SLOT_CENTRE = 4'd4;
  localparam logic [3:0] SLOT_LAST   = 4'd8;

  // Offsets visited in slot order: row above, own row, row below; left to right.
  localparam int OFF_X [0:8] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
  localparam int OFF_Y [0:8] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

  function automatic logic size_legal(input logic [4:0] n);
    return (n == SIZE_S) || (n == SIZE_M) || (n == SIZE_L);
  endfunction

endpackage

// File: rtl/neighbour_addr_gen.sv
// Combinational neighbour address generator: cell + slot offset, with
// bounds check against the board size. Out-of-bounds slots yield address 0.
module neighbour_addr_gen
  import saper_pkg::*;
(
  input  logic [4:0] cell_x_i,
  input  logic [4:0] cell_y_i,
  input  logic [3:0] slot_i,
  input  logic [4:0] size_i,
  output logic       in_bounds_o,
  output logic [4:0] rd_x_o,
  output logic [4:0] rd_y_o
);

  int dx;
  int dy;
  int nx;
  int ny;

  // Apply the slot offset and decide whether the neighbour lies on the board.
  always_comb begin
    dx = 0;
    dy = 0;
    if (slot_i <= SLOT_LAST) begin
      dx = OFF_X[slot_i];
      dy = OFF_Y[slot_i];
    end
    nx = int'(cell_x_i) + dx;
    ny = int'(cell_y_i) + dy;
    in_bounds_o = (nx >= 0) && (nx < int'(size_i)) &&
                  (ny >= 0) && (ny < int'(size_i));
    rd_x_o = in_bounds_o ? nx[4:0] : 5'd0;
    rd_y_o = in_bounds_o ? ny[4:0] : 5'd0;
  end

endmodule

// File: rtl/neighbour_counter.sv
// Mine-board scanner: for every cell (row-major) reads its 3x3 neighbourhood
// from the mine board and writes the neighbour count, or CELL_MINE, to the
// number board. Each cell takes 12 cycles: 9 read slots, drain, write, next.
// Read data returns one cycle after the strobe, so accumulation trails the
// issued slot by one cycle; the drain cycle collects the final slot.
module neighbour_counter
  import saper_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] dimension_size,
  output logic       mine_rd_en,
  output logic [4:0] mine_rd_x,
  output logic [4:0] mine_rd_y,
  input  logic       mine_rd_data,
  output logic       cnt_wr_en,
  output logic [4:0] cnt_wr_x,
  output logic [4:0] cnt_wr_y,
  output logic [3:0] cnt_wr_data,
  output logic       busy,
  output logic       done,
  output state_e     dbg_state
);

  state_e     state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic [4:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  logic [4:0] size_q, size_d;
  logic [3:0] count_q, count_d;
  logic       centre_q, centre_d;

  // Tracks the read issued last cycle so its returning data can be credited.
  logic       acc_pend_q;
  logic [3:0] acc_slot_q;

  // Registered outputs.
  logic       rd_en_q, rd_en_d;
  logic [4:0] rd_x_q, rd_x_d;
  logic [4:0] rd_y_q, rd_y_d;
  logic       wr_en_q, wr_en_d;
  logic [4:0] wr_x_q, wr_x_d;
  logic [4:0] wr_y_q, wr_y_d;
  logic [3:0] wr_data_q, wr_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       gen_in_bounds;
  logic [4:0] gen_x;
  logic [4:0] gen_y;

  // Address for the slot that will be active next cycle, so the read strobe
  // can be registered and still line up with the state.
  neighbour_addr_gen u_addr_gen (
    .cell_x_i    (x_d),
    .cell_y_i    (y_d),
    .slot_i      (slot_d),
    .size_i      (size_d),
    .in_bounds_o (gen_in_bounds),
    .rd_x_o      (gen_x),
    .rd_y_o      (gen_y)
  );

  // Next-state logic: sequencing, pointer advance and accumulation.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    x_d      = x_q;
    y_d      = y_q;
    size_d   = size_q;
    count_d  = count_q;
    centre_d = centre_q;

    if (acc_pend_q) begin
      if (acc_slot_q == SLOT_CENTRE) begin
        centre_d = mine_rd_data;
      end else begin
        count_d = count_q + {3'b000, mine_rd_data};
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start && size_legal(dimension_size)) begin
          size_d  = dimension_size;
          x_d     = 5'd0;
          y_d     = 5'd0;
          slot_d  = 4'd0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (slot_q == SLOT_LAST) begin
          slot_d  = 4'd0;
          state_d = ST_DRAIN;
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      ST_DRAIN: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_NEXT;
      ST_NEXT: begin
        count_d  = 4'd0;
        centre_d = 1'b0;
        slot_d   = 4'd0;
        if (x_q == size_q - 5'd1) begin
          x_d = 5'd0;
          if (y_q == size_q - 5'd1) begin
            state_d = ST_DONE;
          end else begin
            y_d     = y_q + 5'd1;
            state_d = ST_ISSUE;
          end
        end else begin
          x_d     = x_q + 5'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, registered below.
  always_comb begin
    rd_en_d   = (state_d == ST_ISSUE) && gen_in_bounds;
    rd_x_d    = rd_en_d ? gen_x : 5'd0;
    rd_y_d    = rd_en_d ? gen_y : 5'd0;
    wr_en_d   = (state_d == ST_WRITE);
    wr_x_d    = wr_en_d ? x_d : 5'd0;
    wr_y_d    = wr_en_d ? y_d : 5'd0;
    wr_data_d = 4'd0;
    if (wr_en_d) begin
      wr_data_d = centre_d ? CELL_MINE : count_d;
    end
    busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN) ||
             (state_d == ST_WRITE) || (state_d == ST_NEXT);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset abandons any scan in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      slot_q     <= 4'd0;
      x_q        <= 5'd0;
      y_q        <= 5'd0;
      size_q     <= 5'd0;
      count_q    <= 4'd0;
      centre_q   <= 1'b0;
      acc_pend_q <= 1'b0;
      acc_slot_q <= 4'd0;
      rd_en_q    <= 1'b0;
      rd_x_q     <= 5'd0;
      rd_y_q     <= 5'd0;
      wr_en_q    <= 1'b0;
      wr_x_q     <= 5'd0;
      wr_y_q     <= 5'd0;
      wr_data_q  <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      x_q        <= x_d;
      y_q        <= y_d;
      size_q     <= size_d;
      count_q    <= count_d;
      centre_q   <= centre_d;
      acc_pend_q <= rd_en_q;
      acc_slot_q <= slot_q;
      rd_en_q    <= rd_en_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      wr_en_q    <= wr_en_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mine_rd_en  = rd_en_q;
  assign mine_rd_x   = rd_x_q;
  assign mine_rd_y   = rd_y_q;
  assign cnt_wr_en   = wr_en_q;
  assign cnt_wr_x    = wr_x_q;
  assign cnt_wr_y    = wr_y_q;
  assign cnt_wr_data = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_neighbour_counter.sv
// Bench for neighbour_counter: a mine-board memory model with one-cycle read
// latency, a reference that derives expected reads and writes from the board
// contents, and a negedge monitor that pops and compares them.
module tb_neighbour_counter;
  import saper_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] dimension_size;
  logic       mine_rd_en;
  logic [4:0] mine_rd_x;
  logic [4:0] mine_rd_y;
  logic       mine_rd_data;
  logic       cnt_wr_en;
  logic [4:0] cnt_wr_x;
  logic [4:0] cnt_wr_y;
  logic [3:0] cnt_wr_data;
  logic       busy;
  logic       done;
  state_e     dbg_state;

  bit         mines   [0:15][0:15];
  logic [3:0] wr_seen [0:15][0:15];
  logic [9:0]  rd_q[$];   // {y, x}
  logic [13:0] exp_q[$];  // {y, x, data}

  int n_vec = 0;
  int n_err = 0;

  neighbour_counter dut (
    .clk            (clk),
    .rst            (rst_n),
    .start          (start),
    .dimension_size (dimension_size),
    .mine_rd_en     (mine_rd_en),
    .mine_rd_x      (mine_rd_x),
    .mine_rd_y      (mine_rd_y),
    .mine_rd_data   (mine_rd_data),
    .cnt_wr_en      (cnt_wr_en),
    .cnt_wr_x       (cnt_wr_x),
    .cnt_wr_y       (cnt_wr_y),
    .cnt_wr_data    (cnt_wr_data),
    .busy           (busy),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Mine board memory: one-cycle latency, junk when not read.
  always @(posedge clk) begin
    if (mine_rd_en) mine_rd_data <= mines[mine_rd_y[3:0]][mine_rd_x[3:0]];
    else            mine_rd_data <= 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected value %0h at %0t", name, act, $time);
  endtask

  // Monitor: compares every read strobe and every write against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [9:0]  er;
      logic [13:0] ew;
      check("rd_wr_exclusive", 32'(mine_rd_en & cnt_wr_en), 32'd0);
      if (mine_rd_en) begin
        if (rd_q.size() == 0) flag("rd_unexpected", {22'd0, mine_rd_y, mine_rd_x});
        else begin
          er = rd_q.pop_front();
          check("rd_addr", {22'd0, mine_rd_y, mine_rd_x}, {22'd0, er});
        end
      end else if (busy) begin
        check("rd_addr_idle", {22'd0, mine_rd_y, mine_rd_x}, 32'd0);
      end
      if (cnt_wr_en) begin
        if (cnt_wr_x < 5'd16 && cnt_wr_y < 5'd16)
          wr_seen[cnt_wr_y[3:0]][cnt_wr_x[3:0]] = cnt_wr_data;
        if (exp_q.size() == 0) flag("wr_unexpected", {18'd0, cnt_wr_y, cnt_wr_x, cnt_wr_data});
        else begin
          ew = exp_q.pop_front();
          check("wr_cell", {18'd0, cnt_wr_y, cnt_wr_x, cnt_wr_data}, {18'd0, ew});
        end
      end
    end
  end

  // Reference: board-level neighbour counting, row-major cell order.
  task automatic build_expect(input int n);
    for (int y = 0; y < n; y++) begin
      for (int x = 0; x < n; x++) begin
        int cnt = 0;
        logic [3:0] val;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int nx = x + dx;
            int ny = y + dy;
            if (nx >= 0 && nx < n && ny >= 0 && ny < n) begin
              rd_q.push_back({ny[4:0], nx[4:0]});
              if (!(dx == 0 && dy == 0) && mines[ny][nx]) cnt++;
            end
          end
        end
        val = mines[y][x] ? 4'hF : cnt[3:0];
        exp_q.push_back({y[4:0], x[4:0], val});
      end
    end
  endtask

  task automatic clear_board();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        mines[y][x]   = 1'b0;
        wr_seen[y][x] = 4'hE;
      end
  endtask

  // Drives one scan; restart_at > 0 pulses a second start at that cycle.
  task automatic run_scan(input int n, input int restart_at);
    int cycles = 0;
    bit got = 0;
    build_expect(n);
    @(negedge clk);
    dimension_size = 5'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    while (cycles < 12 * n * n + 40) begin
      @(posedge clk);
      cycles++;
      #1;
      if (restart_at != 0 && cycles == restart_at) begin
        start = 1'b1;
        dimension_size = (n == 16) ? 5'd8 : 5'd16;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("done_cycle", 32'(cycles), 32'(12 * n * n));
    check("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("done_pulse", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("writes_left", 32'(exp_q.size()), 32'd0);
    check("reads_left", 32'(rd_q.size()), 32'd0);
    exp_q.delete();
    rd_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, 32'(mine_rd_en), 32'd0);
    check({tag, "_rd_addr"}, {22'd0, mine_rd_y, mine_rd_x}, 32'd0);
    check({tag, "_wr_en"}, 32'(cnt_wr_en), 32'd0);
    check({tag, "_wr_bus"}, {18'd0, cnt_wr_y, cnt_wr_x, cnt_wr_data}, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Stimulus
  initial begin
    logic [4:0] bad_sizes [0:3];
    logic [4:0] good_sizes [0:2];
    bad_sizes  = '{5'd9, 5'd0, 5'd31, 5'd12};
    good_sizes = '{5'd8, 5'd10, 5'd16};
    rst_n = 1'b0;
    start = 1'b0;
    dimension_size = 5'd0;
    clear_board();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Empty 8x8 board.
    run_scan(8, 0);

    // Single mine in the middle of an 8x8 board.
    clear_board();
    mines[3][3] = 1'b1;
    run_scan(8, 0);
    check("single_centre", 32'(wr_seen[3][3]), 32'hF);
    check("single_nbr", 32'(wr_seen[2][2]), 32'd1);
    check("single_nbr2", 32'(wr_seen[4][4]), 32'd1);
    check("single_far", 32'(wr_seen[4][5]), 32'd0);

    // Corner cluster on 10x10, with a start pulse mid-scan that must be ignored.
    clear_board();
    mines[0][0] = 1'b1;
    mines[0][1] = 1'b1;
    mines[1][0] = 1'b1;
    run_scan(10, 50);
    check("corner_11", 32'(wr_seen[1][1]), 32'd3);
    check("corner_00", 32'(wr_seen[0][0]), 32'hF);

    // Illegal sizes are ignored.
    foreach (bad_sizes[i]) begin
      @(negedge clk);
      start = 1'b1;
      dimension_size = bad_sizes[i];
      @(negedge clk);
      start = 1'b0;
      repeat (20) begin
        @(posedge clk);
        #1;
        check("illegal_busy", 32'(busy), 32'd0);
        check("illegal_done", 32'(done), 32'd0);
      end
    end

    // Reset in the middle of a scan.
    clear_board();
    mines[2][5] = 1'b1;
    build_expect(8);
    @(negedge clk);
    dimension_size = 5'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    rd_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      check("post_reset_busy", 32'(busy), 32'd0);
      check("post_reset_done", 32'(done), 32'd0);
    end

    // Fully mined 16x16 board.
    clear_board();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) mines[y][x] = 1'b1;
    run_scan(16, 0);

    // Random boards of random legal size and density.
    repeat (3) begin
      int n;
      int dens;
      clear_board();
      n = int'(good_sizes[$urandom_range(0, 2)]);
      dens = $urandom_range(10, 60);
      for (int y = 0; y < n; y++)
        for (int x = 0; x < n; x++)
          mines[y][x] = ($urandom_range(0, 99) < dens);
      run_scan(n, $urandom_range(0, 1) ? $urandom_range(2, 200) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
